execute_stage: RTL and testbench
================================

EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 Parameter: WIDTH, default 16, datapath width.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Ports from decode register: ALUOp in 2, carrySelect in 2, WB_ALUtoReg/RegWrite/MemRead/MemWrite in 1 each, read_data1/read_data2 in WIDTH, sign_extend in WIDTH, reg_write_address in 3.
REQ-005 Port: stall  in  1  hold EX/MEM register and flags.
REQ-006 Port: flush  in  1  load bubble into EX/MEM register.
REQ-007 Ports to memory stage, all registered: alu_result_r out WIDTH; store_data_r out WIDTH; WB_ALUtoReg_r, RegWrite_r, MemRead_r, MemWrite_r out 1 each; reg_write_address_r out 3.
REQ-008 Port: flags_r  out  3  condition code register {C,N,Z}, bit 2 = C, bit 1 = N, bit 0 = Z.

Function
REQ-009 ALUOp encoding: 00 ADD rd1+rd2; 01 SUB rd1-rd2; 10 AND rd1&rd2; 11 PASS sign_extend (immediate load).
REQ-010 ADD carry: carry-out of the WIDTH-bit sum; SUB carry: carry-out of rd1 + ~rd2 + 1 (1 when rd1 >= rd2 unsigned); AND/PASS: ALU carry 0.
REQ-011 Result truncated to WIDTH bits; no saturation.
REQ-012 carrySelect: 00 hold C; 01 set C=1; 10 clear C=0; 11 C = ALU carry.
REQ-013 Z and N update only when RegWrite=1 and ALUOp != 11: Z = (result == 0), N = result[WIDTH-1]; otherwise hold.
REQ-014 Latency: one cycle; inputs sampled at edge k appear on the *_r outputs after edge k.
REQ-015 store_data_r = read_data2; reg_write_address_r and all four control bits pass through unchanged.
REQ-016 Priority per edge: rst > flush > stall > normal load.
REQ-017 flush: all control outputs 0, alu_result_r = 0, store_data_r = 0, reg_write_address_r = 0; flags hold.
REQ-018 stall (without flush): every register, including flags_r, holds its value.
REQ-019 Flags update only on a normal load cycle; a stalled or flushed instruction never modifies flags.
REQ-020 The flags written at edge k are visible on flags_r after edge k (no bypass of the instruction's own flags).

Reset
REQ-021 With rst high at a rising edge, all outputs become 0, including flags_r = 3'b000; stall and flush are ignored.
REQ-022 Reset mid-operation discards the in-flight instruction; the first edge with rst low performs a normal load.

Structure
REQ-023 ALUOp codes, carrySelect codes and flag bit indices are defined once in the shared defines file used by the control unit and this stage.
REQ-024 The combinational ALU is a sub-module named alu (inputs: a, b, imm, op; outputs: result, carry); the stage wraps it with the flag logic and the EX/MEM register.
REQ-025 The EX/MEM register is built from the codebase's existing parameterised register; the flag register is local.

Verification
REQ-026 ADD 16'hFFFF + 16'h0001, carrySelect=11, RegWrite=1 -> alu_result_r=0, flags_r=3'b101.
REQ-027 SUB 16'h0003 - 16'h0005, carrySelect=11, RegWrite=1 -> alu_result_r=16'hFFFE, flags_r=3'b010.
REQ-028 PASS sign_extend=16'h8000, carrySelect=01, prior flags 3'b001 -> alu_result_r=16'h8000, flags_r=3'b101 (Z/N unchanged).
REQ-029 Load AND 16'h00F0 & 16'h0F00, then stall=1 for 2 cycles with new inputs -> outputs and flags frozen at result 0 / Z=1 for both cycles.
REQ-030 stall=1 and flush=1 together with MemWrite=1 -> MemWrite_r=0, RegWrite_r=0, flags unchanged.
REQ-031 rst=1 together with flush=1 and a valid ADD -> all outputs 0; next cycle with rst=0, ADD 2+3 -> alu_result_r=5.

Source files
------------

// File: rtl/execute_stage_pkg.sv
// Shared encodings for the execute stage: ALU opcodes, carry-select codes,
// condition-code bit positions and the control bundle carried into EX/MEM.
package execute_stage_pkg;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'b00,
        ALU_SUB  = 2'b01,
        ALU_AND  = 2'b10,
        ALU_PASS = 2'b11
    } alu_op_e;

    typedef enum logic [1:0] {
        CSEL_HOLD  = 2'b00,
        CSEL_SET   = 2'b01,
        CSEL_CLEAR = 2'b10,
        CSEL_ALU   = 2'b11
    } carry_sel_e;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;

    typedef struct packed {
        logic       wbAluToReg;
        logic       regWrite;
        logic       memRead;
        logic       memWrite;
        logic [2:0] regWriteAddress;
    } ex_ctrl_t;

    // Carry flag update chosen by the instruction's carry-select field.
    function automatic logic selectCarry(input carry_sel_e sel,
                                         input logic       oldCarry,
                                         input logic       aluCarry);
        logic c;
        c = oldCarry;
        case (sel)
            CSEL_HOLD:  c = oldCarry;
            CSEL_SET:   c = 1'b1;
            CSEL_CLEAR: c = 1'b0;
            CSEL_ALU:   c = aluCarry;
            default:    c = oldCarry;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/execute_stage_alu.sv
// Combinational ALU: add, subtract, bitwise AND, or pass-through of the
// sign-extended immediate, with the carry-out of the add/subtract adder.
module alu
    import execute_stage_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] imm,
    input  logic [1:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             carry
);

    logic [WIDTH:0] w_sum;

    // Subtraction reuses the adder as a + ~b + 1 so its carry means a >= b unsigned.
    always_comb begin
        w_sum  = '0;
        result = '0;
        carry  = 1'b0;
        case (alu_op_e'(op))
            ALU_ADD: begin
                w_sum  = {1'b0, a} + {1'b0, b};
                result = w_sum[WIDTH-1:0];
                carry  = w_sum[WIDTH];
            end
            ALU_SUB: begin
                w_sum  = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                result = w_sum[WIDTH-1:0];
                carry  = w_sum[WIDTH];
            end
            ALU_AND: begin
                result = a & b;
            end
            ALU_PASS: begin
                result = imm;
            end
            default: begin
                result = '0;
            end
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: ALU plus condition-code logic feeding the EX/MEM pipeline
// register, with stall (hold) and flush (bubble) control.
module execute_stage
    import execute_stage_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       ALUOp,
    input  logic [1:0]       carrySelect,
    input  logic             WB_ALUtoReg,
    input  logic             RegWrite,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic [WIDTH-1:0] read_data1,
    input  logic [WIDTH-1:0] read_data2,
    input  logic [WIDTH-1:0] sign_extend,
    input  logic [2:0]       reg_write_address,
    input  logic             stall,
    input  logic             flush,
    output logic [WIDTH-1:0] alu_result_r,
    output logic [WIDTH-1:0] store_data_r,
    output logic             WB_ALUtoReg_r,
    output logic             RegWrite_r,
    output logic             MemRead_r,
    output logic             MemWrite_r,
    output logic [2:0]       reg_write_address_r,
    output logic [2:0]       flags_r
);

    logic [WIDTH-1:0] w_aluResult;
    logic             w_aluCarry;
    logic [2:0]       w_flagsNext;
    ex_ctrl_t         w_ctrlIn;

    logic [WIDTH-1:0] r_aluResult;
    logic [WIDTH-1:0] r_storeData;
    ex_ctrl_t         r_ctrl;
    logic [2:0]       r_flags;

    alu #(.WIDTH(WIDTH)) u_alu (
        .a      (read_data1),
        .b      (read_data2),
        .imm    (sign_extend),
        .op     (ALUOp),
        .result (w_aluResult),
        .carry  (w_aluCarry)
    );

    assign w_ctrlIn = '{
        wbAluToReg:      WB_ALUtoReg,
        regWrite:        RegWrite,
        memRead:         MemRead,
        memWrite:        MemWrite,
        regWriteAddress: reg_write_address
    };

    // Z/N follow only register-writing ALU results; immediate loads leave them alone.
    always_comb begin
        w_flagsNext         = r_flags;
        w_flagsNext[FLAG_C] = selectCarry(carry_sel_e'(carrySelect), r_flags[FLAG_C], w_aluCarry);
        if (RegWrite && (alu_op_e'(ALUOp) != ALU_PASS)) begin
            w_flagsNext[FLAG_Z] = (w_aluResult == '0);
            w_flagsNext[FLAG_N] = w_aluResult[WIDTH-1];
        end
    end

    // EX/MEM register: reset beats flush beats stall; flags move only on a real load.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_aluResult <= '0;
            r_storeData <= '0;
            r_ctrl      <= '0;
            r_flags     <= '0;
        end else if (flush) begin
            r_aluResult <= '0;
            r_storeData <= '0;
            r_ctrl      <= '0;
        end else if (!stall) begin
            r_aluResult <= w_aluResult;
            r_storeData <= read_data2;
            r_ctrl      <= w_ctrlIn;
            r_flags     <= w_flagsNext;
        end
    end

    assign alu_result_r        = r_aluResult;
    assign store_data_r        = r_storeData;
    assign WB_ALUtoReg_r       = r_ctrl.wbAluToReg;
    assign RegWrite_r          = r_ctrl.regWrite;
    assign MemRead_r           = r_ctrl.memRead;
    assign MemWrite_r          = r_ctrl.memWrite;
    assign reg_write_address_r = r_ctrl.regWriteAddress;
    assign flags_r             = r_flags;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed vectors push hand-computed
// expectations, a negedge monitor pops and compares the registered outputs.
module tb_execute_stage;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       ALUOp;
    logic [1:0]       carrySelect;
    logic             WB_ALUtoReg, RegWrite, MemRead, MemWrite;
    logic [WIDTH-1:0] read_data1, read_data2, sign_extend;
    logic [2:0]       reg_write_address;
    logic             stall, flush;
    logic [WIDTH-1:0] alu_result_r, store_data_r;
    logic             WB_ALUtoReg_r, RegWrite_r, MemRead_r, MemWrite_r;
    logic [2:0]       reg_write_address_r;
    logic [2:0]       flags_r;

    typedef struct {
        string            name;
        logic [WIDTH-1:0] result;
        logic [WIDTH-1:0] store;
        logic [6:0]       ctrl;
        logic [2:0]       flags;
    } exp_t;

    exp_t expQ[$];
    int   numVectors     = 0;
    int   numMiscompares = 0;

    execute_stage #(.WIDTH(WIDTH)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .ALUOp               (ALUOp),
        .carrySelect         (carrySelect),
        .WB_ALUtoReg         (WB_ALUtoReg),
        .RegWrite            (RegWrite),
        .MemRead             (MemRead),
        .MemWrite            (MemWrite),
        .read_data1          (read_data1),
        .read_data2          (read_data2),
        .sign_extend         (sign_extend),
        .reg_write_address   (reg_write_address),
        .stall               (stall),
        .flush               (flush),
        .alu_result_r        (alu_result_r),
        .store_data_r        (store_data_r),
        .WB_ALUtoReg_r       (WB_ALUtoReg_r),
        .RegWrite_r          (RegWrite_r),
        .MemRead_r           (MemRead_r),
        .MemWrite_r          (MemWrite_r),
        .reg_write_address_r (reg_write_address_r),
        .flags_r             (flags_r)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input string field,
                               input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        numVectors++;
        if (actual !== expected) begin
            numMiscompares++;
            $display("[TB] FAIL %s.%s actual=%h expected=%h", name, field, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; the expectation is queued after the rising edge.
    task automatic applyStimulus(input string name, input logic r, input logic fl, input logic st,
                                 input logic [1:0] op, input logic [1:0] cs,
                                 input logic [3:0] ctl, input logic [2:0] addr,
                                 input logic [WIDTH-1:0] rd1, input logic [WIDTH-1:0] rd2,
                                 input logic [WIDTH-1:0] imm,
                                 input logic [WIDTH-1:0] eRes, input logic [WIDTH-1:0] eStore,
                                 input logic [6:0] eCtrl, input logic [2:0] eFlags);
        exp_t e;
        @(negedge clk);
        rst = r; flush = fl; stall = st;
        ALUOp = op; carrySelect = cs;
        {WB_ALUtoReg, RegWrite, MemRead, MemWrite} = ctl;
        reg_write_address = addr;
        read_data1 = rd1; read_data2 = rd2; sign_extend = imm;
        @(posedge clk);
        e.name = name; e.result = eRes; e.store = eStore; e.ctrl = eCtrl; e.flags = eFlags;
        expQ.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput(e.name, "alu_result", alu_result_r, e.result);
                checkOutput(e.name, "store_data", store_data_r, e.store);
                checkOutput(e.name, "ctrl", {9'd0, WB_ALUtoReg_r, RegWrite_r, MemRead_r,
                                             MemWrite_r, reg_write_address_r}, {9'd0, e.ctrl});
                checkOutput(e.name, "flags", {13'd0, flags_r}, {13'd0, e.flags});
            end
        end
    end

    initial begin : stimulus
        int waitCycles;
        rst = 1'b1; flush = 1'b0; stall = 1'b0; ALUOp = 2'b00; carrySelect = 2'b00;
        {WB_ALUtoReg, RegWrite, MemRead, MemWrite} = 4'b0000;
        reg_write_address = 3'd0; read_data1 = '0; read_data2 = '0; sign_extend = '0;

        //            name            rst fl st op     cs     {wb,rw,mr,mw} addr rd1       rd2       imm       result    store     ctrl        flags
        applyStimulus("resetFlush",   1, 1, 0, 2'b00, 2'b11, 4'b1101, 3'd5, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 7'b0000_000, 3'b000);
        applyStimulus("add2p3",       0, 0, 0, 2'b00, 2'b11, 4'b1100, 3'd3, 16'h0002, 16'h0003, 16'h0000, 16'h0005, 16'h0003, 7'b1100_011, 3'b000);
        applyStimulus("addWrap",      0, 0, 0, 2'b00, 2'b11, 4'b0100, 3'd1, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h0001, 7'b0100_001, 3'b101);
        applyStimulus("subNeg",       0, 0, 0, 2'b01, 2'b11, 4'b0100, 3'd4, 16'h0003, 16'h0005, 16'h0000, 16'hFFFE, 16'h0005, 7'b0100_100, 3'b010);
        applyStimulus("subZeroClrC",  0, 0, 0, 2'b01, 2'b10, 4'b0100, 3'd6, 16'h0005, 16'h0005, 16'h0000, 16'h0000, 16'h0005, 7'b0100_110, 3'b001);
        applyStimulus("passImm",      0, 0, 0, 2'b11, 2'b01, 4'b0100, 3'd7, 16'h0007, 16'h0009, 16'h8000, 16'h8000, 16'h0009, 7'b0100_111, 3'b101);
        applyStimulus("andLoad",      0, 0, 0, 2'b10, 2'b00, 4'b1100, 3'd2, 16'h00F0, 16'h0F00, 16'h0000, 16'h0000, 16'h0F00, 7'b1100_010, 3'b101);
        applyStimulus("stall1",       0, 0, 1, 2'b00, 2'b10, 4'b0101, 3'd5, 16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0F00, 7'b1100_010, 3'b101);
        applyStimulus("stall2",       0, 0, 1, 2'b01, 2'b10, 4'b0111, 3'd6, 16'h0009, 16'h0004, 16'h0000, 16'h0000, 16'h0F00, 7'b1100_010, 3'b101);
        applyStimulus("stallFlush",   0, 1, 1, 2'b00, 2'b10, 4'b0101, 3'd3, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 7'b0000_000, 3'b101);
        applyStimulus("carryNoRw",    0, 0, 0, 2'b00, 2'b11, 4'b0010, 3'd1, 16'h8000, 16'h8001, 16'h0000, 16'h0001, 16'h8001, 7'b0010_001, 3'b101);
        applyStimulus("andNeg",       0, 0, 0, 2'b10, 2'b10, 4'b0100, 3'd2, 16'hF0F0, 16'hFF00, 16'h0000, 16'hF000, 16'hFF00, 7'b0100_010, 3'b010);
        applyStimulus("flushOnly",    0, 1, 0, 2'b01, 2'b01, 4'b1111, 3'd7, 16'h0001, 16'h0002, 16'h0000, 16'h0000, 16'h0000, 7'b0000_000, 3'b010);
        applyStimulus("passCarry0",   0, 0, 0, 2'b11, 2'b11, 4'b0100, 3'd4, 16'hFFFF, 16'hFFFF, 16'h1234, 16'h1234, 16'hFFFF, 7'b0100_100, 3'b010);
        applyStimulus("addHoldC",     0, 0, 0, 2'b00, 2'b00, 4'b1100, 3'd3, 16'h1234, 16'h1111, 16'h0000, 16'h2345, 16'h1111, 7'b1100_011, 3'b000);
        applyStimulus("setCThenSub",  0, 0, 0, 2'b01, 2'b11, 4'b0100, 3'd1, 16'h0009, 16'h0004, 16'h0000, 16'h0005, 16'h0004, 7'b0100_001, 3'b100);
        applyStimulus("midReset",     1, 1, 1, 2'b00, 2'b11, 4'b1111, 3'd7, 16'h0002, 16'h0003, 16'h0000, 16'h0000, 16'h0000, 7'b0000_000, 3'b000);
        applyStimulus("postReset",    0, 0, 0, 2'b00, 2'b11, 4'b1100, 3'd3, 16'h0002, 16'h0003, 16'h0000, 16'h0005, 16'h0003, 7'b1100_011, 3'b000);

        waitCycles = 0;
        while (expQ.size() > 0 && waitCycles < 20) begin
            @(posedge clk);
            waitCycles++;
        end
        @(posedge clk);
        numVectors++;
        if (expQ.size() != 0) begin
            numMiscompares++;
            $display("[TB] FAIL drain pending=%0d required=0", expQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
        $finish;
    end

endmodule
